ex_stage: RTL and testbench

- Execute stage of the 5-stage ARMv8 (LEGv8 subset) pipeline. Sits directly downstream of the ID/EX pipeline register and upstream of EX/MEM.
- Contains the operand forwarding muxes, a single-cycle ALU and CBZ/CBNZ/B branch resolution.
- MUL is handled by an iterative shift-add multiplier FSM. While it runs, the block holds the front of the pipeline through stall_req.

---
 rtl/ex_stage_pkg.sv | 27 ++
 rtl/ex_stage_seq_mul.sv | 76 +++++++
 rtl/ex_stage.sv | 116 +++++++++++
 tb/tb_ex_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: opcodes, ALUOp codes, forwarding
// selects and multiplier FSM state encodings.
package ex_stage_pkg;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_LSL = 11'b11010011011;
    localparam logic [10:0] OP_LSR = 11'b11010011010;
    localparam logic [10:0] OP_MUL = 11'b10011011000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_stage_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles
// in BUSY, then one DONE cycle presenting the low DATA_W bits of the product.
module seq_mul
    import ex_stage_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MUL_CNT_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam logic [MUL_CNT_W-1:0] LAST_CNT = MUL_CNT_W'(DATA_W - 1);

    mul_state_e           r_state;
    mul_state_e           w_next;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]    r_acc;
    logic [DATA_W-1:0]    r_mcand;
    logic [DATA_W-1:0]    r_mplier;

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            MUL_IDLE: begin
                if (start && !flush) w_next = MUL_BUSY;
            end
            MUL_BUSY: begin
                busy = 1'b1;
                if (flush)                  w_next = MUL_IDLE;
                else if (r_cnt == LAST_CNT) w_next = MUL_DONE;
            end
            MUL_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = MUL_IDLE;
            end
            default: w_next = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MUL_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == MUL_IDLE && start && !flush) begin
                r_mcand  <= a;
                r_mplier <= b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == MUL_BUSY && !flush) begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, CBZ/CBNZ/B resolution,
// and the iterative multiplier that stalls the front of the pipe while it runs.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MUL_CNT_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       ex_opcode,
    input  logic [1:0]        ex_ALUOp,
    input  logic              ex_ALUSrc,
    input  logic [DATA_W-1:0] ex_reg1,
    input  logic [DATA_W-1:0] ex_reg2,
    input  logic [DATA_W-1:0] ex_imm,
    input  logic [5:0]        ex_shamt,
    input  logic [63:0]       ex_pc,
    input  logic              ex_isZeroBranch,
    input  logic              ex_isNZBranch,
    input  logic              ex_isUnconBranch,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic [DATA_W-1:0] wb_fwd_data,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] store_data,
    output logic              zero,
    output logic              branch_taken,
    output logic [63:0]       branch_target,
    output logic              stall_req,
    output logic              mul_busy
);

    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0]        sel,
                                                  input logic [DATA_W-1:0] rf,
                                                  input logic [DATA_W-1:0] mem,
                                                  input logic [DATA_W-1:0] wb);
        case (sel)
            FWD_MEM: return mem;
            FWD_WB:  return wb;
            default: return rf;
        endcase
    endfunction

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b_raw;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_product;
    logic              w_is_mul;
    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [63:0]       w_offset;

    assign w_a        = fwd_mux(fwd_a, ex_reg1, mem_fwd_data, wb_fwd_data);
    assign w_b_raw    = fwd_mux(fwd_b, ex_reg2, mem_fwd_data, wb_fwd_data);
    assign w_b        = ex_ALUSrc ? ex_imm : w_b_raw;
    assign store_data = w_b_raw;

    assign w_is_mul    = (ex_ALUOp == ALUOP_RTYPE) && (ex_opcode == OP_MUL);
    assign w_mul_start = w_is_mul && !flush && !w_mul_busy;

    seq_mul #(
        .DATA_W    (DATA_W),
        .MUL_CNT_W (MUL_CNT_W)
    ) u_seq_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .flush   (flush),
        .a       (w_a),
        .b       (w_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    always_comb begin
        w_alu = '0;
        case (ex_ALUOp)
            ALUOP_ADD:   w_alu = w_a + w_b;
            ALUOP_PASSB: w_alu = w_b;
            ALUOP_RTYPE: begin
                case (ex_opcode)
                    OP_ADD:  w_alu = w_a + w_b;
                    OP_SUB:  w_alu = w_a - w_b;
                    OP_AND:  w_alu = w_a & w_b;
                    OP_ORR:  w_alu = w_a | w_b;
                    OP_LSL:  w_alu = w_a << ex_shamt;
                    OP_LSR:  w_alu = w_a >> ex_shamt;
                    OP_MUL:  w_alu = w_product;
                    default: w_alu = '0;
                endcase
            end
            default: w_alu = '0;
        endcase
    end

    // Reset forces the visible outputs quiet even while ID/EX still holds an instruction.
    assign alu_result = rst ? '0 : w_alu;
    assign zero       = (alu_result == '0);

    assign w_offset      = 64'($signed(ex_imm)) << 2;
    assign branch_target = ex_pc + w_offset;
    assign branch_taken  = !rst && !flush &&
                           (ex_isUnconBranch || (ex_isZeroBranch && zero) ||
                            (ex_isNZBranch && !zero));

    // DONE releases the stall so ID/EX can advance while the product is presented.
    assign stall_req = !rst && (w_mul_start || (w_mul_busy && !w_mul_done));
    assign mul_busy  = w_mul_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of single-cycle ALU/branch vectors plus
// hand-written multiplier, flush and reset sequences.
module tb_ex_stage;

    localparam logic [10:0] T_ADD = 11'b10001011000;
    localparam logic [10:0] T_SUB = 11'b11001011000;
    localparam logic [10:0] T_AND = 11'b10001010000;
    localparam logic [10:0] T_ORR = 11'b10101010000;
    localparam logic [10:0] T_LSL = 11'b11010011011;
    localparam logic [10:0] T_LSR = 11'b11010011010;
    localparam logic [10:0] T_MUL = 11'b10011011000;
    localparam logic [10:0] T_BAD = 11'b11111111111;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] ex_opcode;
    logic [1:0]  ex_ALUOp;
    logic        ex_ALUSrc;
    logic [63:0] ex_reg1, ex_reg2, ex_imm, ex_pc;
    logic [5:0]  ex_shamt;
    logic        ex_isZeroBranch, ex_isNZBranch, ex_isUnconBranch;
    logic [1:0]  fwd_a, fwd_b;
    logic [63:0] mem_fwd_data, wb_fwd_data;
    logic        flush;
    logic [63:0] alu_result, store_data, branch_target;
    logic        zero, branch_taken, stall_req, mul_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(64), .MUL_CNT_W(7)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_opcode        (ex_opcode),
        .ex_ALUOp         (ex_ALUOp),
        .ex_ALUSrc        (ex_ALUSrc),
        .ex_reg1          (ex_reg1),
        .ex_reg2          (ex_reg2),
        .ex_imm           (ex_imm),
        .ex_shamt         (ex_shamt),
        .ex_pc            (ex_pc),
        .ex_isZeroBranch  (ex_isZeroBranch),
        .ex_isNZBranch    (ex_isNZBranch),
        .ex_isUnconBranch (ex_isUnconBranch),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .mem_fwd_data     (mem_fwd_data),
        .wb_fwd_data      (wb_fwd_data),
        .flush            (flush),
        .alu_result       (alu_result),
        .store_data       (store_data),
        .zero             (zero),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .stall_req        (stall_req),
        .mul_busy         (mul_busy)
    );

    typedef struct {
        string       name;
        logic [10:0] op;
        logic [1:0]  aluop;
        logic        src;
        logic [1:0]  fa, fb;
        logic [63:0] r1, r2, imm, mem, wb, pc;
        logic [5:0]  sh;
        logic        zb, nzb, ub, fl;
        logic [63:0] e_alu, e_sd, e_tgt;
        logic        e_zero, e_tk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t blank(input string name);
        vec_t v;
        v.name = name; v.op = T_ADD; v.aluop = 2'b10; v.src = 1'b0;
        v.fa = 2'b00; v.fb = 2'b00; v.r1 = '0; v.r2 = '0; v.imm = '0;
        v.mem = '0; v.wb = '0; v.pc = '0; v.sh = '0;
        v.zb = 1'b0; v.nzb = 1'b0; v.ub = 1'b0; v.fl = 1'b0;
        v.e_alu = '0; v.e_sd = '0; v.e_tgt = '0; v.e_zero = 1'b0; v.e_tk = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        ex_opcode = v.op; ex_ALUOp = v.aluop; ex_ALUSrc = v.src;
        fwd_a = v.fa; fwd_b = v.fb; ex_reg1 = v.r1; ex_reg2 = v.r2;
        ex_imm = v.imm; mem_fwd_data = v.mem; wb_fwd_data = v.wb;
        ex_pc = v.pc; ex_shamt = v.sh; ex_isZeroBranch = v.zb;
        ex_isNZBranch = v.nzb; ex_isUnconBranch = v.ub; flush = v.fl;
    endtask

    task automatic issue_mul(input logic [63:0] a, input logic [63:0] b);
        vec_t v;
        v = blank("mul"); v.op = T_MUL; v.r1 = a; v.r2 = b;
        apply(v);
    endtask

    task automatic nop();
        vec_t v;
        v = blank("nop"); v.aluop = 2'b00;
        apply(v);
    endtask

    // Counts stall cycles from issue until DONE (stall_req drops); bounded.
    task automatic run_mul(input string name, output int stalls, output logic ok);
        stalls = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!stall_req) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: stall_req still high after 200 cycles", name);
        end
    endtask

    initial begin
        vec_t v;
        int   stalls;
        logic ok;

        v = blank("add");  v.r1 = 5; v.r2 = 7; v.e_alu = 12; v.e_sd = 7;
        tbl.push_back(v);
        v = blank("sub_cbz"); v.op = T_SUB; v.r1 = 9; v.fb = 2'b10; v.mem = 9;
        v.zb = 1; v.pc = 64'h100; v.imm = 64'hFFFF_FFFF_FFFF_FFFC;
        v.e_alu = 0; v.e_zero = 1; v.e_tk = 1; v.e_sd = 9; v.e_tgt = 64'hF0;
        tbl.push_back(v);
        v.name = "sub_cbz_flush"; v.fl = 1; v.e_tk = 0;
        tbl.push_back(v);
        v = blank("and"); v.op = T_AND; v.r1 = 64'hF0F0; v.r2 = 64'hFF00;
        v.e_alu = 64'hF000; v.e_sd = 64'hFF00;
        tbl.push_back(v);
        v = blank("orr"); v.op = T_ORR; v.r1 = 64'hF0F0; v.r2 = 64'h0F0F;
        v.e_alu = 64'hFFFF; v.e_sd = 64'h0F0F;
        tbl.push_back(v);
        v = blank("lsl63"); v.op = T_LSL; v.r1 = 1; v.sh = 63;
        v.e_alu = 64'h8000_0000_0000_0000;
        tbl.push_back(v);
        v = blank("lsr63"); v.op = T_LSR; v.r1 = 64'h8000_0000_0000_0000; v.sh = 63;
        v.e_alu = 1;
        tbl.push_back(v);
        v = blank("unknown"); v.op = T_BAD; v.r1 = 3; v.r2 = 4;
        v.e_alu = 0; v.e_zero = 1; v.e_sd = 4;
        tbl.push_back(v);
        v = blank("ldst_add"); v.aluop = 2'b00; v.src = 1; v.r1 = 64'h1000;
        v.imm = 64'h20; v.r2 = 64'h55; v.e_alu = 64'h1020; v.e_sd = 64'h55;
        v.e_tgt = 64'h80;
        tbl.push_back(v);
        v = blank("cbnz_taken"); v.aluop = 2'b01; v.r2 = 5; v.nzb = 1;
        v.pc = 64'h200; v.imm = 3; v.e_alu = 5; v.e_sd = 5; v.e_tk = 1;
        v.e_tgt = 64'h20C;
        tbl.push_back(v);
        v = blank("cbz_not"); v.aluop = 2'b01; v.r2 = 1; v.zb = 1;
        v.e_alu = 1; v.e_sd = 1;
        tbl.push_back(v);
        v = blank("b_uncond"); v.aluop = 2'b01; v.ub = 1; v.pc = 64'h40;
        v.imm = ONES; v.e_zero = 1; v.e_tk = 1; v.e_tgt = 64'h3C;
        tbl.push_back(v);
        v = blank("fwd_wb_11"); v.fa = 2'b01; v.wb = 100; v.r1 = 999;
        v.fb = 2'b11; v.r2 = 1; v.mem = 77; v.e_alu = 101; v.e_sd = 1;
        tbl.push_back(v);
        v = blank("sub_wrap"); v.op = T_SUB; v.r1 = 0; v.r2 = 1;
        v.e_alu = ONES; v.e_sd = 1;
        tbl.push_back(v);
        v = blank("add_wrap"); v.r1 = ONES; v.r2 = 2; v.e_alu = 1; v.e_sd = 2;
        tbl.push_back(v);
        v = blank("src_fwdmem"); v.aluop = 2'b00; v.src = 1; v.fb = 2'b10;
        v.mem = 64'hABC; v.r2 = 64'h111; v.r1 = 4; v.imm = 8;
        v.e_alu = 12; v.e_sd = 64'hABC; v.e_tgt = 64'h20;
        tbl.push_back(v);

        // Reset: outputs quiet even with live instructions in ID/EX.
        rst = 1'b1;
        v = blank("rst"); v.r1 = 5; v.r2 = 7; v.ub = 1;
        apply(v);
        @(posedge clk); #1;
        chk("rst_alu", alu_result, 64'd0);
        chk("rst_taken", {63'd0, branch_taken}, 64'd0);
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_busy", {63'd0, mul_busy}, 64'd0);
        issue_mul(7, 9);
        @(posedge clk); #1;
        chk("rst_mul_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_mul_busy", {63'd0, mul_busy}, 64'd0);
        @(negedge clk);
        nop();
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            chk({tbl[i].name, "_alu"}, alu_result, tbl[i].e_alu);
            chk({tbl[i].name, "_zero"}, {63'd0, zero}, {63'd0, tbl[i].e_zero});
            chk({tbl[i].name, "_taken"}, {63'd0, branch_taken}, {63'd0, tbl[i].e_tk});
            chk({tbl[i].name, "_target"}, branch_target, tbl[i].e_tgt);
            chk({tbl[i].name, "_store"}, store_data, tbl[i].e_sd);
            chk({tbl[i].name, "_stall"}, {63'd0, stall_req}, 64'd0);
        end

        // Full MUL: all-ones x 3, stall for DATA_W+1 cycles, result in DONE.
        @(negedge clk);
        issue_mul(ONES, 3);
        #1;
        chk("mul_issue_stall", {63'd0, stall_req}, 64'd1);
        chk("mul_issue_busy", {63'd0, mul_busy}, 64'd0);
        run_mul("mul_big", stalls, ok);
        chk("mul_big_stalls", 64'(stalls), 64'd65);
        chk("mul_big_result", alu_result, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul_big_done_busy", {63'd0, mul_busy}, 64'd1);
        chk("mul_big_done_zero", {63'd0, zero}, 64'd0);
        nop();
        @(posedge clk); #1;
        chk("mul_big_idle_busy", {63'd0, mul_busy}, 64'd0);
        chk("mul_big_idle_stall", {63'd0, stall_req}, 64'd0);

        // Flush in BUSY cycle 10, then a fresh MUL must start from a clean accumulator.
        @(negedge clk);
        issue_mul(6, 7);
        repeat (10) @(posedge clk);
        #1;
        chk("flush_pre_busy", {63'd0, mul_busy}, 64'd1);
        flush = 1'b1;
        #1;
        chk("flush_pre_stall", {63'd0, stall_req}, 64'd1);
        @(posedge clk); #1;
        chk("flush_idle_busy", {63'd0, mul_busy}, 64'd0);
        chk("flush_idle_stall", {63'd0, stall_req}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        issue_mul(2, 3);
        #1;
        run_mul("mul_2x3", stalls, ok);
        chk("mul_2x3_stalls", 64'(stalls), 64'd65);
        chk("mul_2x3_result", alu_result, 64'd6);
        nop();
        @(posedge clk); #1;

        // Reset at BUSY cycle 30: quiet outputs, FSM back to IDLE.
        @(negedge clk);
        issue_mul(5, 5);
        repeat (30) @(posedge clk);
        #1;
        chk("rst_mid_pre_busy", {63'd0, mul_busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_alu", alu_result, 64'd0);
        chk("rst_mid_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_mid_busy", {63'd0, mul_busy}, 64'd0);
        chk("rst_mid_taken", {63'd0, branch_taken}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nop();
        @(posedge clk); #1;
        chk("rst_mid_after_busy", {63'd0, mul_busy}, 64'd0);
        chk("rst_mid_after_stall", {63'd0, stall_req}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
